dcpu16_fetch: RTL and testbench



---
 rtl/dcpu16_fetch_if.sv | 49 ++++
 rtl/dcpu16_fetch.sv | 96 +++++++++
 tb/tb_dcpu16_fetch.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/dcpu16_fetch_if.sv
// Fetch-stage bus: RAM read port, PC redirect and the assembled-instruction handshake.
// master = fetch stage, slave = RAM/execute-core side.
interface dcpu16_fetch_if;
   logic [15:0] ram_addr;
   logic [15:0] ram_dout;
   logic        pc_load;
   logic [15:0] pc_new;
   logic        inst_valid;
   logic        inst_ready;
   logic [3:0]  inst_opcode;
   logic [5:0]  inst_a;
   logic [5:0]  inst_b;
   logic [15:0] inst_nw_a;
   logic [15:0] inst_nw_b;
   logic [15:0] inst_pc;
   logic [1:0]  inst_len;

   modport master (
      output ram_addr,
      input  ram_dout,
      input  pc_load,
      input  pc_new,
      output inst_valid,
      input  inst_ready,
      output inst_opcode,
      output inst_a,
      output inst_b,
      output inst_nw_a,
      output inst_nw_b,
      output inst_pc,
      output inst_len
   );

   modport slave (
      input  ram_addr,
      output ram_dout,
      output pc_load,
      output pc_new,
      input  inst_valid,
      output inst_ready,
      input  inst_opcode,
      input  inst_a,
      input  inst_b,
      input  inst_nw_a,
      input  inst_nw_b,
      input  inst_pc,
      input  inst_len
   );
endinterface

// File: rtl/dcpu16_fetch.sv
// DCPU16 fetch/pre-decode: owns the PC, gathers opcode and next-word operands,
// and presents one assembled instruction per valid/ready handshake.
module dcpu16_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic           clk,
   input  logic           rst_n,
   dcpu16_fetch_if.master bus
);

   typedef enum logic [1:0] {S_OP, S_A, S_B, S_HOLD} state_t;

   state_t      state, state_nxt;
   logic [15:0] pc;
   logic [15:0] ir;
   logic [15:0] nw_a;
   logic [15:0] nw_b;
   logic [15:0] inst_pc;
   logic [1:0]  len;
   logic        valid_q;

   logic [15:0] word;
   logic        need_a;
   logic        need_b;

   function automatic logic needs_word(input logic [5:0] v);
      return (v[5:3] == 3'b010) || (v == 6'h1e) || (v == 6'h1f);
   endfunction

   // In S_OP the opcode word is still on ram_dout; afterwards it lives in ir.
   assign word   = (state == S_OP) ? bus.ram_dout : ir;
   assign need_a = (word[3:0] != 4'h0) && needs_word(word[9:4]);
   assign need_b = needs_word(word[15:10]);

   always_comb begin
      state_nxt = state;
      case (state)
         S_OP:    state_nxt = need_a ? S_A : (need_b ? S_B : S_HOLD);
         S_A:     state_nxt = need_b ? S_B : S_HOLD;
         S_B:     state_nxt = S_HOLD;
         S_HOLD:  if (bus.inst_ready) state_nxt = S_OP;
         default: state_nxt = S_OP;
      endcase
      if (bus.pc_load) state_nxt = S_OP;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_OP;
         pc      <= RESET_PC;
         ir      <= '0;
         nw_a    <= '0;
         nw_b    <= '0;
         inst_pc <= '0;
         len     <= '0;
         valid_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         valid_q <= (state_nxt == S_HOLD);
         if (bus.pc_load) begin
            pc <= bus.pc_new;
         end else begin
            case (state)
               S_OP: begin
                  ir      <= bus.ram_dout;
                  inst_pc <= pc;
                  pc      <= pc + 16'd1;
                  nw_a    <= '0;
                  nw_b    <= '0;
                  len     <= 2'd1 + 2'(need_a) + 2'(need_b);
               end
               S_A: begin
                  nw_a <= bus.ram_dout;
                  pc   <= pc + 16'd1;
               end
               S_B: begin
                  nw_b <= bus.ram_dout;
                  pc   <= pc + 16'd1;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.ram_addr    = pc;
   assign bus.inst_valid  = valid_q;
   assign bus.inst_opcode = ir[3:0];
   assign bus.inst_a      = ir[9:4];
   assign bus.inst_b      = ir[15:10];
   assign bus.inst_nw_a   = nw_a;
   assign bus.inst_nw_b   = nw_b;
   assign bus.inst_pc     = inst_pc;
   assign bus.inst_len    = len;

endmodule

// File: tb/tb_dcpu16_fetch.sv
// Directed testbench for dcpu16_fetch: table of sequential instructions plus
// hand-written stall, redirect, PC-wrap and mid-fetch reset sequences.
module tb_dcpu16_fetch;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [15:0] ram [0:65535];

   dcpu16_fetch_if bus ();

   dcpu16_fetch #(.RESET_PC(16'h0000)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.ram_dout = ram[bus.ram_addr];

   typedef struct {
      logic [15:0] addr;
      logic [15:0] w0, w1, w2;
      logic [3:0]  op;
      logic [5:0]  a, b;
      logic [15:0] nwa, nwb;
      logic [1:0]  len;
   } vec_t;

   vec_t vecs [8];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!bus.inst_valid && cyc < 10) begin
         step();
         cyc++;
      end
      check("valid_timeout", 16'(bus.inst_valid), 16'h1);
   endtask

   initial begin
      int cyc;

      for (int i = 0; i < 65536; i++) ram[i] = 16'h0000;

      vecs[0] = '{16'h0000, 16'h8401, 16'h0000, 16'h0000, 4'h1, 6'h00, 6'h21, 16'h0000, 16'h0000, 2'd1};
      vecs[1] = '{16'h0001, 16'h7de1, 16'h1000, 16'h0020, 4'h1, 6'h1e, 6'h1f, 16'h1000, 16'h0020, 2'd3};
      vecs[2] = '{16'h0004, 16'h7c10, 16'h0018, 16'h0000, 4'h0, 6'h01, 6'h1f, 16'h0000, 16'h0018, 2'd2};
      vecs[3] = '{16'h0006, 16'h0102, 16'h1234, 16'h0000, 4'h2, 6'h10, 6'h00, 16'h1234, 16'h0000, 2'd2};
      vecs[4] = '{16'h0008, 16'h5d73, 16'haaaa, 16'h5555, 4'h3, 6'h17, 6'h17, 16'haaaa, 16'h5555, 2'd3};
      vecs[5] = '{16'h000b, 16'h61e0, 16'h0000, 16'h0000, 4'h0, 6'h1e, 6'h18, 16'h0000, 16'h0000, 2'd1};
      vecs[6] = '{16'h000c, 16'h74f5, 16'h0000, 16'h0000, 4'h5, 6'h0f, 6'h1d, 16'h0000, 16'h0000, 2'd1};
      vecs[7] = '{16'h000d, 16'h01ff, 16'hbeef, 16'h0000, 4'hf, 6'h1f, 6'h00, 16'hbeef, 16'h0000, 2'd2};

      foreach (vecs[i]) begin
         ram[vecs[i].addr] = vecs[i].w0;
         if (vecs[i].len > 2'd1) ram[vecs[i].addr + 16'd1] = vecs[i].w1;
         if (vecs[i].len > 2'd2) ram[vecs[i].addr + 16'd2] = vecs[i].w2;
      end
      ram[16'h000f] = 16'h8401;
      ram[16'h0010] = 16'h7de1;
      ram[16'h0011] = 16'h1111;
      ram[16'h0012] = 16'h2222;
      ram[16'h0040] = 16'h8802;

      rst_n          = 1'b0;
      bus.inst_ready = 1'b0;
      bus.pc_load    = 1'b0;
      bus.pc_new     = 16'h0000;
      repeat (3) step();

      check("rst_valid",   16'(bus.inst_valid),  16'h0);
      check("rst_addr",    bus.ram_addr,         16'h0000);
      check("rst_opcode",  16'(bus.inst_opcode), 16'h0);
      check("rst_b",       16'(bus.inst_b),      16'h0);
      check("rst_pc",      bus.inst_pc,          16'h0000);
      check("rst_len",     16'(bus.inst_len),    16'h0);
      rst_n = 1'b1;
      check("start_addr",  bus.ram_addr,         16'h0000);

      for (int i = 0; i < 8; i++) begin
         cyc = 0;
         while (!bus.inst_valid && cyc < 10) begin
            step();
            cyc++;
            check("addr_seq", bus.ram_addr, vecs[i].addr + 16'(cyc));
         end
         check("valid",   16'(bus.inst_valid),  16'h1);
         check("latency", 16'(cyc),             16'(vecs[i].len));
         check("opcode",  16'(bus.inst_opcode), 16'(vecs[i].op));
         check("a",       16'(bus.inst_a),      16'(vecs[i].a));
         check("b",       16'(bus.inst_b),      16'(vecs[i].b));
         check("nw_a",    bus.inst_nw_a,        vecs[i].nwa);
         check("nw_b",    bus.inst_nw_b,        vecs[i].nwb);
         check("inst_pc", bus.inst_pc,          vecs[i].addr);
         check("len",     16'(bus.inst_len),    16'(vecs[i].len));
         bus.inst_ready = 1'b1;
         step();
         bus.inst_ready = 1'b0;
         check("valid_drop", 16'(bus.inst_valid), 16'h0);
      end

      // stall: outputs and ram_addr frozen while ready is low
      wait_valid(cyc);
      for (int k = 0; k < 5; k++) begin
         step();
         check("hold_valid",  16'(bus.inst_valid),  16'h1);
         check("hold_opcode", 16'(bus.inst_opcode), 16'h1);
         check("hold_b",      16'(bus.inst_b),      16'h21);
         check("hold_pc",     bus.inst_pc,          16'h000f);
         check("hold_addr",   bus.ram_addr,         16'h0010);
      end
      bus.inst_ready = 1'b1;
      step();
      bus.inst_ready = 1'b0;
      check("hold_release", 16'(bus.inst_valid), 16'h0);
      check("hold_next",    bus.ram_addr,        16'h0010);

      // redirect during S_A of a 3-word instruction
      step();
      bus.pc_load = 1'b1;
      bus.pc_new  = 16'h0040;
      step();
      bus.pc_load = 1'b0;
      check("redir_valid", 16'(bus.inst_valid), 16'h0);
      check("redir_addr",  bus.ram_addr,        16'h0040);
      wait_valid(cyc);
      check("redir_pc",     bus.inst_pc,          16'h0040);
      check("redir_opcode", 16'(bus.inst_opcode), 16'h2);
      check("redir_b",      16'(bus.inst_b),      16'h22);
      check("redir_lat",    16'(cyc),             16'd1);

      // redirect coincident with handshake, landing at 0xFFFF to exercise the wrap
      ram[16'hffff] = 16'h7c01;
      ram[16'h0000] = 16'h0030;
      bus.inst_ready = 1'b1;
      bus.pc_load    = 1'b1;
      bus.pc_new     = 16'hffff;
      step();
      bus.inst_ready = 1'b0;
      bus.pc_load    = 1'b0;
      check("hs_redir_valid", 16'(bus.inst_valid), 16'h0);
      check("hs_redir_addr",  bus.ram_addr,        16'hffff);
      wait_valid(cyc);
      check("wrap_lat",    16'(cyc),             16'd2);
      check("wrap_pc",     bus.inst_pc,          16'hffff);
      check("wrap_opcode", 16'(bus.inst_opcode), 16'h1);
      check("wrap_b",      16'(bus.inst_b),      16'h1f);
      check("wrap_nw_a",   bus.inst_nw_a,        16'h0000);
      check("wrap_nw_b",   bus.inst_nw_b,        16'h0030);
      check("wrap_len",    16'(bus.inst_len),    16'd2);
      check("wrap_addr",   bus.ram_addr,         16'h0001);

      // asynchronous reset in the middle of S_B
      bus.inst_ready = 1'b1;
      step();
      bus.inst_ready = 1'b0;
      step();
      step();
      check("midb_nw_a", bus.inst_nw_a, 16'h1000);
      rst_n = 1'b0;
      #1;
      check("arst_valid",  16'(bus.inst_valid),  16'h0);
      check("arst_addr",   bus.ram_addr,         16'h0000);
      check("arst_opcode", 16'(bus.inst_opcode), 16'h0);
      check("arst_a",      16'(bus.inst_a),      16'h0);
      check("arst_nw_a",   bus.inst_nw_a,        16'h0000);
      check("arst_pc",     bus.inst_pc,          16'h0000);
      check("arst_len",    16'(bus.inst_len),    16'h0);
      #10;
      rst_n = 1'b1;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
